// File: rtl/secure_regfile_mp.sv
// Two-write / three-read register store with a hardware clear sweep after reset,
// write-first read bypass (ALU over LSU) and a lockable key region.
module secure_regfile_mp #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       KEY_BASE  = 1008,
  parameter int unsigned       KEY_SIZE  = 16,
  parameter int unsigned       KEY_W     = 16,
  parameter logic [KEY_W-1:0]  KEY_VALUE = 16'h0032
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] reg1_i,
  input  logic [ADDR_W-1:0] reg2_i,
  output logic [DATA_W-1:0] read_reg1_o,
  output logic [DATA_W-1:0] read_reg2_o,
  input  logic [ADDR_W-1:0] address_to_mem_i,
  output logic [DATA_W-1:0] memory_out_o,
  input  logic              we_mem_i,
  input  logic [ADDR_W-1:0] address_mem_i,
  input  logic [DATA_W-1:0] write_data_mem_i,
  input  logic              we_alu_i,
  input  logic [ADDR_W-1:0] address_alu_i,
  input  logic [DATA_W-1:0] write_data_alu_i,
  input  logic              unlock_req_i,
  input  logic [KEY_W-1:0]  unlock_key_i,
  input  logic              lock_req_i,
  output logic              locked_o,
  output logic              busy_o,
  output logic              viol_o,
  output logic [KEY_W-1:0]  key_access_o
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   KEY_LO_C = (ADDR_W+1)'(KEY_BASE);
  localparam logic [ADDR_W:0]   KEY_HI_C = (ADDR_W+1)'(KEY_BASE + KEY_SIZE);
  localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                viol_q, viol_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   rdm_q, rdm_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                alu_wr, mem_wr;
  logic                alu_rej, mem_rej;
  logic                rd1_rej, rd2_rej, rdm_rej;
  logic                bad_key;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic in_key(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= KEY_LO_C) && ({1'b0, a} < KEY_HI_C);
  endfunction

  // Write-first read: a same-edge write (ALU first, then LSU) overrides the stored word.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              blocked,
    input logic              aw,
    input logic [ADDR_W-1:0] aa,
    input logic [DATA_W-1:0] ad,
    input logic              mw,
    input logic [ADDR_W-1:0] ma,
    input logic [DATA_W-1:0] md
  );
    logic [DATA_W-1:0] v;
    if (!in_range(a) || blocked) begin
      v = '0;
    end else if (aw && (aa == a)) begin
      v = ad;
    end else if (mw && (ma == a)) begin
      v = md;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Access qualification against the current (pre-edge) lock state.
  always_comb begin
    alu_rej = we_alu_i && in_range(address_alu_i) && locked_q && in_key(address_alu_i);
    mem_rej = we_mem_i && in_range(address_mem_i) && locked_q && in_key(address_mem_i);
    alu_wr  = we_alu_i && in_range(address_alu_i) && !alu_rej;
    mem_wr  = we_mem_i && in_range(address_mem_i) && !mem_rej;
    rd1_rej = locked_q && in_key(reg1_i);
    rd2_rej = locked_q && in_key(reg2_i);
    rdm_rej = locked_q && in_key(address_to_mem_i);
    bad_key = unlock_req_i && (unlock_key_i != KEY_VALUE);
  end

  // Next-state: clear sweep, then normal reads, violation and lock handling.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    viol_d   = 1'b0;
    rd1_d    = '0;
    rd2_d    = '0;
    rdm_d    = '0;
    case (state_q)
      S_CLEAR: begin
        if (ptr_q == LAST_C) begin
          state_d = S_RUN;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        rd1_d  = read_port(reg1_i, mem_q[reg1_i], rd1_rej, alu_wr, address_alu_i,
                           write_data_alu_i, mem_wr, address_mem_i, write_data_mem_i);
        rd2_d  = read_port(reg2_i, mem_q[reg2_i], rd2_rej, alu_wr, address_alu_i,
                           write_data_alu_i, mem_wr, address_mem_i, write_data_mem_i);
        rdm_d  = read_port(address_to_mem_i, mem_q[address_to_mem_i], rdm_rej, alu_wr,
                           address_alu_i, write_data_alu_i, mem_wr, address_mem_i,
                           write_data_mem_i);
        viol_d = alu_rej || mem_rej || rd1_rej || rd2_rej || rdm_rej || bad_key;
        if (lock_req_i) begin
          locked_d = 1'b1;
        end else if (unlock_req_i && !bad_key) begin
          locked_d = 1'b0;
        end else begin
          locked_d = locked_q;
        end
      end
      default: begin
        state_d  = S_CLEAR;
        ptr_d    = '0;
        busy_d   = 1'b1;
        locked_d = 1'b1;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_CLEAR;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      locked_q <= 1'b1;
      viol_q   <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      rdm_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      viol_q   <= viol_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      rdm_q    <= rdm_d;
    end
  end

  // Storage array; the ALU write is issued last so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == S_CLEAR)) begin
      mem_q[ptr_q] <= '0;
    end else if (!rst_i && (state_q == S_RUN)) begin
      if (mem_wr) begin
        mem_q[address_mem_i] <= write_data_mem_i;
      end
      if (alu_wr) begin
        mem_q[address_alu_i] <= write_data_alu_i;
      end
    end
  end

  assign read_reg1_o  = rd1_q;
  assign read_reg2_o  = rd2_q;
  assign memory_out_o = rdm_q;
  assign locked_o     = locked_q;
  assign busy_o       = busy_q;
  assign viol_o       = viol_q;
  assign key_access_o = locked_q ? {KEY_W{1'b0}} : KEY_VALUE;

endmodule
